// File: rtl/cpu_branch_pkg.sv
// rtl/cpu_branch_pkg.sv - shared types and encodings for the 8086 short-branch condition unit
package cpu_branch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EVAL = 2'b01,
      RESP = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      KIND_JCC  = 2'b00,
      KIND_LOOP = 2'b01,
      KIND_JMP  = 2'b10,
      KIND_RSVD = 2'b11
   } kind_t;

   // Jcc condition codes: low nibble of opcodes 0x70-0x7F
   localparam logic [3:0] JO  = 4'h0;
   localparam logic [3:0] JNO = 4'h1;
   localparam logic [3:0] JB  = 4'h2;
   localparam logic [3:0] JNB = 4'h3;
   localparam logic [3:0] JE  = 4'h4;
   localparam logic [3:0] JNE = 4'h5;
   localparam logic [3:0] JBE = 4'h6;
   localparam logic [3:0] JA  = 4'h7;
   localparam logic [3:0] JS  = 4'h8;
   localparam logic [3:0] JNS = 4'h9;
   localparam logic [3:0] JP  = 4'hA;
   localparam logic [3:0] JNP = 4'hB;
   localparam logic [3:0] JL  = 4'hC;
   localparam logic [3:0] JGE = 4'hD;
   localparam logic [3:0] JLE = 4'hE;
   localparam logic [3:0] JG  = 4'hF;

   // Loop-family selectors carried in req_cc[1:0]
   localparam logic [1:0] LOOP_NE   = 2'b00;
   localparam logic [1:0] LOOP_E    = 2'b01;
   localparam logic [1:0] LOOP_ANY  = 2'b10;
   localparam logic [1:0] LOOP_JCXZ = 2'b11;

endpackage

// File: rtl/branch_cond_unit_if.sv
// rtl/branch_cond_unit_if.sv - decode request, flags and writeback response bundle
interface branch_cond_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_kind;
   logic [3:0]  req_cc;
   logic [15:0] req_ip;
   logic [7:0]  req_disp;
   logic [15:0] cx_in;
   logic        zero_flag;
   logic        sign_flag;
   logic        carry_flag;
   logic        overflow_flag;
   logic        parity_flag;
   logic        flags_pending;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_taken;
   logic [15:0] rsp_next_ip;
   logic [15:0] rsp_cx;
   logic        rsp_cx_we;
   logic        rsp_err;

   // decode / flags / writeback side
   modport master (
      output req_valid, req_kind, req_cc, req_ip, req_disp, cx_in,
      output zero_flag, sign_flag, carry_flag, overflow_flag, parity_flag, flags_pending,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_taken, rsp_next_ip, rsp_cx, rsp_cx_we, rsp_err
   );

   // branch unit side
   modport slave (
      input  req_valid, req_kind, req_cc, req_ip, req_disp, cx_in,
      input  zero_flag, sign_flag, carry_flag, overflow_flag, parity_flag, flags_pending,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_taken, rsp_next_ip, rsp_cx, rsp_cx_we, rsp_err
   );

endinterface

// File: rtl/jcc_cond_eval.sv
// rtl/jcc_cond_eval.sv - combinational 8086 Jcc condition evaluator
module jcc_cond_eval
   import cpu_branch_pkg::*;
(
   input  logic [3:0] cc,
   input  logic       zf,
   input  logic       sf,
   input  logic       cf,
   input  logic       of,
   input  logic       pf,
   output logic       taken
);

   // Map the condition code onto the flag expression it names
   always_comb begin
      taken = 1'b0;
      case (cc)
         JO:      taken = of;
         JNO:     taken = !of;
         JB:      taken = cf;
         JNB:     taken = !cf;
         JE:      taken = zf;
         JNE:     taken = !zf;
         JBE:     taken = cf | zf;
         JA:      taken = !(cf | zf);
         JS:      taken = sf;
         JNS:     taken = !sf;
         JP:      taken = pf;
         JNP:     taken = !pf;
         JL:      taken = sf ^ of;
         JGE:     taken = !(sf ^ of);
         JLE:     taken = zf | (sf ^ of);
         JG:      taken = !(zf | (sf ^ of));
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - short conditional transfer unit; loop family enabled by BRANCH_LOOP_EN
module branch_cond_unit
   import cpu_branch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   branch_cond_unit_if.slave  bus
);

   state_t      state;
   kind_t       lat_kind;
   logic [3:0]  lat_cc;
   logic [15:0] lat_ip;
   logic [7:0]  lat_disp;
   logic [15:0] lat_cx;

   logic        jcc_taken;
   logic [15:0] target_ip;
   logic        e_taken;
   logic [15:0] e_next_ip;
   logic [15:0] e_cx;
   logic        e_cx_we;
   logic        e_err;

   // Flags come live from the flags register so they are sampled at the EVAL edge, not at accept
   jcc_cond_eval u_jcc (
      .cc    (lat_cc),
      .zf    (bus.zero_flag),
      .sf    (bus.sign_flag),
      .cf    (bus.carry_flag),
      .of    (bus.overflow_flag),
      .pf    (bus.parity_flag),
      .taken (jcc_taken)
   );

   assign target_ip = lat_ip + {{8{lat_disp[7]}}, lat_disp};

`ifdef BRANCH_LOOP_EN
   logic [15:0] cx_dec;
   assign cx_dec = lat_cx - 16'd1;
`endif

   // Decision datapath: taken, next IP and CX writeback for the latched request
   always_comb begin
      e_taken = 1'b0;
      e_cx    = lat_cx;
      e_cx_we = 1'b0;
      e_err   = 1'b0;
      case (lat_kind)
         KIND_JCC: e_taken = jcc_taken;
         KIND_JMP: e_taken = 1'b1;
         KIND_LOOP: begin
`ifdef BRANCH_LOOP_EN
            case (lat_cc[1:0])
               LOOP_NE: begin
                  e_taken = (cx_dec != 16'd0) && !bus.zero_flag;
                  e_cx    = cx_dec;
                  e_cx_we = 1'b1;
               end
               LOOP_E: begin
                  e_taken = (cx_dec != 16'd0) && bus.zero_flag;
                  e_cx    = cx_dec;
                  e_cx_we = 1'b1;
               end
               LOOP_ANY: begin
                  e_taken = (cx_dec != 16'd0);
                  e_cx    = cx_dec;
                  e_cx_we = 1'b1;
               end
               LOOP_JCXZ: e_taken = (lat_cx == 16'd0);
               default:   e_taken = 1'b0;
            endcase
`else
            e_err = 1'b1;
`endif
         end
         default: e_err = 1'b1;
      endcase
      e_next_ip = e_taken ? target_ip : lat_ip;
   end

   // Request/evaluate/respond sequencer with registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.req_ready   <= 1'b1;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_taken   <= 1'b0;
         bus.rsp_next_ip <= 16'd0;
         bus.rsp_cx      <= 16'd0;
         bus.rsp_cx_we   <= 1'b0;
         bus.rsp_err     <= 1'b0;
         lat_kind        <= KIND_JCC;
         lat_cc          <= 4'd0;
         lat_ip          <= 16'd0;
         lat_disp        <= 8'd0;
         lat_cx          <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_kind      <= kind_t'(bus.req_kind);
                  lat_cc        <= bus.req_cc;
                  lat_ip        <= bus.req_ip;
                  lat_disp      <= bus.req_disp;
                  lat_cx        <= bus.cx_in;
                  bus.req_ready <= 1'b0;
                  state         <= EVAL;
               end
            end
            EVAL: begin
               if (!bus.flags_pending) begin
                  bus.rsp_taken   <= e_taken;
                  bus.rsp_next_ip <= e_next_ip;
                  bus.rsp_cx      <= e_cx;
                  bus.rsp_cx_we   <= e_cx_we;
                  bus.rsp_err     <= e_err;
                  bus.rsp_valid   <= 1'b1;
                  state           <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.rsp_valid <= 1'b0;
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - directed-vector bench for branch_cond_unit
module tb_branch_cond_unit;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   int   lat;

   branch_cond_unit_if bif ();

   branch_cond_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_flags(input logic z, input logic s, input logic c, input logic o, input logic p);
      bif.zero_flag     = z;
      bif.sign_flag     = s;
      bif.carry_flag    = c;
      bif.overflow_flag = o;
      bif.parity_flag   = p;
   endtask

   task automatic issue(input logic [1:0] kind, input logic [3:0] cc, input logic [15:0] ip,
                        input logic [7:0] disp, input logic [15:0] cx);
      @(negedge clk);
      check("req_ready_before_issue", bif.req_ready, 1);
      bif.req_valid = 1'b1;
      bif.req_kind  = kind;
      bif.req_cc    = cc;
      bif.req_ip    = ip;
      bif.req_disp  = disp;
      bif.cx_in     = cx;
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      bif.req_kind  = 2'b11;
      bif.req_cc    = ~cc;
      bif.req_ip    = 16'hDEAD;
      bif.req_disp  = 8'h80;
      bif.cx_in     = 16'hBEEF;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bif.rsp_valid && n < 20);
      if (!bif.rsp_valid) check("rsp_timeout", bif.rsp_valid, 1);
   endtask

   task automatic check_rsp(input string tag, input logic taken, input logic [15:0] nip,
                            input logic [15:0] cx, input logic we, input logic err);
      check({tag, "_valid"}, bif.rsp_valid, 1);
      check({tag, "_taken"}, bif.rsp_taken, taken);
      check({tag, "_next_ip"}, bif.rsp_next_ip, nip);
      check({tag, "_cx"}, bif.rsp_cx, cx);
      check({tag, "_cx_we"}, bif.rsp_cx_we, we);
      check({tag, "_err"}, bif.rsp_err, err);
   endtask

   task automatic finish_rsp();
      bif.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bif.rsp_ready = 1'b0;
   endtask

   initial begin
      tests_run          = 0;
      tests_failed       = 0;
      rst                = 1'b1;
      bif.req_valid      = 1'b0;
      bif.req_kind       = 2'b00;
      bif.req_cc         = 4'h0;
      bif.req_ip         = 16'h0;
      bif.req_disp       = 8'h0;
      bif.cx_in          = 16'h0;
      bif.flags_pending  = 1'b0;
      bif.rsp_ready      = 1'b0;
      set_flags(0, 0, 0, 0, 0);

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", bif.req_ready, 1);
      check("rst_rsp_valid", bif.rsp_valid, 0);
      check("rst_taken", bif.rsp_taken, 0);
      check("rst_next_ip", bif.rsp_next_ip, 0);
      check("rst_cx", bif.rsp_cx, 0);
      check("rst_cx_we", bif.rsp_cx_we, 0);
      check("rst_err", bif.rsp_err, 0);

      // JE taken with ZF=1, backward displacement, two-cycle latency
      set_flags(1, 0, 0, 0, 0);
      issue(2'b00, 4'h4, 16'h0100, 8'hFE, 16'h1234);
      wait_rsp(lat);
      check("je_latency", lat, 2);
      check_rsp("je", 1, 16'h00FE, 16'h1234, 0, 0);
      finish_rsp();

      // JL with SF==OF not taken, then SF!=OF taken
      set_flags(0, 1, 0, 1, 0);
      issue(2'b00, 4'hC, 16'h2000, 8'h10, 16'h0007);
      wait_rsp(lat);
      check_rsp("jl_nt", 0, 16'h2000, 16'h0007, 0, 0);
      finish_rsp();
      set_flags(0, 1, 0, 0, 0);
      issue(2'b00, 4'hC, 16'h2000, 8'h10, 16'h0007);
      wait_rsp(lat);
      check_rsp("jl_t", 1, 16'h2010, 16'h0007, 0, 0);
      finish_rsp();

      // JA with CF=0, ZF=0 and JP with PF=0
      set_flags(0, 0, 0, 0, 0);
      issue(2'b00, 4'h7, 16'h3000, 8'h05, 16'h0000);
      wait_rsp(lat);
      check_rsp("ja", 1, 16'h3005, 16'h0000, 0, 0);
      finish_rsp();
      issue(2'b00, 4'hA, 16'h3000, 8'h05, 16'h0000);
      wait_rsp(lat);
      check_rsp("jp", 0, 16'h3000, 16'h0000, 0, 0);
      finish_rsp();

      // loop family
      set_flags(1, 0, 0, 0, 0);
      issue(2'b01, 4'h2, 16'h4000, 8'hF0, 16'h0001);
      wait_rsp(lat);
`ifdef BRANCH_LOOP_EN
      check_rsp("loop_cx1", 0, 16'h4000, 16'h0000, 1, 0);
`else
      check_rsp("loop_cx1", 0, 16'h4000, 16'h0001, 0, 1);
`endif
      finish_rsp();
      issue(2'b01, 4'h2, 16'h4000, 8'hF0, 16'h0000);
      wait_rsp(lat);
`ifdef BRANCH_LOOP_EN
      check_rsp("loop_cx0", 1, 16'h3FF0, 16'hFFFF, 1, 0);
`else
      check_rsp("loop_cx0", 0, 16'h4000, 16'h0000, 0, 1);
`endif
      finish_rsp();
      issue(2'b01, 4'h1, 16'h4000, 8'h08, 16'h0005);
      wait_rsp(lat);
`ifdef BRANCH_LOOP_EN
      check_rsp("loope", 1, 16'h4008, 16'h0004, 1, 0);
`else
      check_rsp("loope", 0, 16'h4000, 16'h0005, 0, 1);
`endif
      finish_rsp();
      issue(2'b01, 4'h0, 16'h4000, 8'h08, 16'h0005);
      wait_rsp(lat);
`ifdef BRANCH_LOOP_EN
      check_rsp("loopne", 0, 16'h4000, 16'h0004, 1, 0);
`else
      check_rsp("loopne", 0, 16'h4000, 16'h0005, 0, 1);
`endif
      finish_rsp();
      issue(2'b01, 4'h3, 16'h4000, 8'h08, 16'h0000);
      wait_rsp(lat);
`ifdef BRANCH_LOOP_EN
      check_rsp("jcxz", 1, 16'h4008, 16'h0000, 0, 0);
`else
      check_rsp("jcxz", 0, 16'h4000, 16'h0000, 0, 1);
`endif
      finish_rsp();

      // flags_pending for 3 cycles; ZF rises in the last pending cycle
      set_flags(0, 0, 0, 0, 0);
      bif.flags_pending = 1'b1;
      issue(2'b00, 4'h4, 16'h5000, 8'h20, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pend_no_rsp", bif.rsp_valid, 0);
      bif.zero_flag = 1'b1;
      @(negedge clk);
      bif.flags_pending = 1'b0;
      wait_rsp(lat);
      check("pend_latency", lat + 4, 5);
      check_rsp("pend_je", 1, 16'h5020, 16'h0000, 0, 0);
      finish_rsp();

      // JMP short wraps; reserved kind errors
      issue(2'b10, 4'h9, 16'hFFF0, 8'h7F, 16'h0011);
      wait_rsp(lat);
      check_rsp("jmp_wrap", 1, 16'h006F, 16'h0011, 0, 0);
      finish_rsp();
      issue(2'b11, 4'h4, 16'h6000, 8'h10, 16'h0022);
      wait_rsp(lat);
      check_rsp("rsvd", 0, 16'h6000, 16'h0022, 0, 1);
      finish_rsp();

      // backpressure: outputs hold for 4 cycles while flags wander
      set_flags(0, 0, 0, 0, 0);
      issue(2'b00, 4'h5, 16'h7000, 8'h80, 16'h0033);
      wait_rsp(lat);
      for (int i = 0; i < 4; i++) begin
         set_flags(1, 1, 1, 1, 1);
         check_rsp("hold", 1, 16'h6F80, 16'h0033, 0, 0);
         check("hold_req_ready", bif.req_ready, 0);
         @(negedge clk);
      end
      finish_rsp();
      @(negedge clk);
      check("post_rsp_req_ready", bif.req_ready, 1);
      check("post_rsp_valid", bif.rsp_valid, 0);

      // reset during EVAL drops the request
      bif.flags_pending = 1'b1;
      issue(2'b10, 4'h0, 16'h8000, 8'h01, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bif.flags_pending = 1'b0;
      @(negedge clk);
      check("rst_eval_req_ready", bif.req_ready, 1);
      for (int i = 0; i < 4; i++) begin
         check("rst_eval_no_rsp", bif.rsp_valid, 0);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
